// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: request/response bundle between register read and writeback.
// master drives requests and accepts results; slave is the execute unit.
interface alu_exec_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      opcode;
  logic [2:0]      func3;
  logic [6:0]      func7;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [3:0]      alu_control;
  logic            illegal;

  modport master (
    output in_valid,
    output opcode,
    output func3,
    output func7,
    output op_a,
    output op_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result,
    input  zero,
    input  alu_control,
    input  illegal
  );

  modport slave (
    input  in_valid,
    input  opcode,
    input  func3,
    input  func7,
    input  op_a,
    input  op_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result,
    output zero,
    output alu_control,
    output illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I ALU decode and execute between register read and writeback.
// Shifts run bit-serially (ITER_SHIFT=1) or through a barrel shifter (ITER_SHIFT=0).
module alu_exec_unit #(
  parameter int XLEN       = 32,
  parameter int ITER_SHIFT = 1,
  parameter int SHW        = $clog2(XLEN)
) (
  input logic            clk,
  input logic            rst,
  alu_exec_unit_if.slave bus
);

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;
  localparam logic [3:0] ALU_ILL   = 4'b1111;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          state;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic [3:0]      ctl_q;
  logic            ill_q;
  logic [SHW-1:0]  cnt;
  logic [XLEN-1:0] sh_val;

  logic [3:0]      dec;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] res_c;
  logic [XLEN-1:0] sh_nxt;
  logic            accept;
  logic            is_shift;
  logic            go_iter;

  function automatic logic [3:0] base_op(
    input logic [2:0] f3
  );
    logic [3:0] c;
    case (f3)
      3'b000:  c = ALU_ADD;
      3'b001:  c = ALU_SLL;
      3'b010:  c = ALU_SLT;
      3'b011:  c = ALU_SLTU;
      3'b100:  c = ALU_XOR;
      3'b101:  c = ALU_SRL;
      3'b110:  c = ALU_OR;
      default: c = ALU_AND;
    endcase
    return c;
  endfunction

  function automatic logic [XLEN-1:0] alu_eval(
    input logic [3:0]      c,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b,
    input logic [SHW-1:0]  s
  );
    logic [XLEN-1:0] r;
    case (c)
      ALU_AND:   r = a & b;
      ALU_OR:    r = a | b;
      ALU_ADD:   r = a + b;
      ALU_XOR:   r = a ^ b;
      ALU_SUB:   r = a - b;
      ALU_SLL:   r = a << s;
      ALU_SRL:   r = a >> s;
      ALU_SRA:   r = $unsigned($signed(a) >>> s);
      ALU_SLT:   r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:  r = {{(XLEN-1){1'b0}}, a < b};
      ALU_PASSB: r = b;
      default:   r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    dec = ALU_ILL;
    unique case (1'b1)
      (bus.opcode == OPC_LOAD),
      (bus.opcode == OPC_STORE),
      (bus.opcode == OPC_JAL),
      (bus.opcode == OPC_AUIPC): dec = ALU_ADD;
      (bus.opcode == OPC_JALR): begin
        if (bus.func3 == 3'b000) dec = ALU_ADD;
      end
      (bus.opcode == OPC_LUI): dec = ALU_PASSB;
      (bus.opcode == OPC_BRANCH): begin
        case (bus.func3[2:1])
          2'b00:   dec = ALU_SUB;
          2'b10:   dec = ALU_SLT;
          2'b11:   dec = ALU_SLTU;
          default: dec = ALU_ILL;
        endcase
      end
      (bus.opcode == OPC_OP): begin
        if (bus.func7 == F7_BASE) begin
          dec = base_op(bus.func3);
        end else if (bus.func7 == F7_ALT) begin
          if (bus.func3 == 3'b000) dec = ALU_SUB;
          else if (bus.func3 == 3'b101) dec = ALU_SRA;
        end
      end
      (bus.opcode == OPC_OPIMM): begin
        case (bus.func3)
          3'b001: begin
            if (bus.func7 == F7_BASE) dec = ALU_SLL;
          end
          3'b101: begin
            if (bus.func7 == F7_BASE) dec = ALU_SRL;
            else if (bus.func7 == F7_ALT) dec = ALU_SRA;
          end
          default: dec = base_op(bus.func3);
        endcase
      end
      default: dec = ALU_ILL;
    endcase
  end

  assign shamt    = bus.op_b[SHW-1:0];
  assign res_c    = alu_eval(dec, bus.op_a, bus.op_b, shamt);
  assign is_shift = (dec == ALU_SLL) || (dec == ALU_SRL) ||
                    (dec == ALU_SRA);
  assign go_iter  = (ITER_SHIFT != 0) && is_shift &&
                    (shamt != '0);

  assign bus.in_ready = (state == IDLE) ||
                        (state == DONE && bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;

  // One-bit step of the held shift operand.
  always_comb begin
    case (ctl_q)
      ALU_SLL: sh_nxt = sh_val << 1;
      ALU_SRA: sh_nxt = {sh_val[XLEN-1], sh_val[XLEN-1:1]};
      default: sh_nxt = sh_val >> 1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ctl_q       <= ALU_AND;
      ill_q       <= 1'b0;
      cnt         <= '0;
      sh_val      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            ctl_q <= dec;
            ill_q <= (dec == ALU_ILL);
            if (go_iter) begin
              state       <= SHIFT;
              cnt         <= shamt;
              sh_val      <= bus.op_a;
              out_valid_q <= 1'b0;
            end else begin
              state       <= DONE;
              result_q    <= res_c;
              zero_q      <= (res_c == '0);
              out_valid_q <= 1'b1;
            end
          end else if (state == DONE && bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        SHIFT: begin
          sh_val <= sh_nxt;
          cnt    <= cnt - 1'b1;
          if (cnt == SHW'(1)) begin
            state       <= DONE;
            result_q    <= sh_nxt;
            zero_q      <= (sh_nxt == '0);
            out_valid_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.zero        = zero_q;
  assign bus.alu_control = ctl_q;
  assign bus.illegal     = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench for an iterative and a barrel instance.
// Expected responses come from a rule-level reference model.
module tb_alu_exec_unit;

  typedef enum {
    O_ADD, O_SUB, O_SLL, O_SRL, O_SRA, O_SLT,
    O_SLTU, O_XOR, O_OR, O_AND, O_PASSB, O_ILL
  } op_e;

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid[2];
  logic [6:0]  opc[2];
  logic [2:0]  fn3[2];
  logic [6:0]  fn7[2];
  logic [31:0] opa[2];
  logic [31:0] opb[2];
  logic        ordy[2];
  logic        ir[2];
  logic        ov[2];
  logic [31:0] res[2];
  logic        zr[2];
  logic [3:0]  ctl[2];
  logic        ill[2];

  alu_exec_unit_if #(.XLEN(32)) bus0 ();
  alu_exec_unit_if #(.XLEN(32)) bus1 ();

  assign bus0.in_valid  = in_valid[0];
  assign bus0.opcode    = opc[0];
  assign bus0.func3     = fn3[0];
  assign bus0.func7     = fn7[0];
  assign bus0.op_a      = opa[0];
  assign bus0.op_b      = opb[0];
  assign bus0.out_ready = ordy[0];
  assign ir[0]  = bus0.in_ready;
  assign ov[0]  = bus0.out_valid;
  assign res[0] = bus0.result;
  assign zr[0]  = bus0.zero;
  assign ctl[0] = bus0.alu_control;
  assign ill[0] = bus0.illegal;

  assign bus1.in_valid  = in_valid[1];
  assign bus1.opcode    = opc[1];
  assign bus1.func3     = fn3[1];
  assign bus1.func7     = fn7[1];
  assign bus1.op_a      = opa[1];
  assign bus1.op_b      = opb[1];
  assign bus1.out_ready = ordy[1];
  assign ir[1]  = bus1.in_ready;
  assign ov[1]  = bus1.out_valid;
  assign res[1] = bus1.result;
  assign zr[1]  = bus1.zero;
  assign ctl[1] = bus1.alu_control;
  assign ill[1] = bus1.illegal;

  alu_exec_unit #(.XLEN(32), .ITER_SHIFT(1)) u_iter (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  alu_exec_unit #(.XLEN(32), .ITER_SHIFT(0)) u_bar (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   mode = 0;
  exp_t sbq[2][$];
  bit   pres[2];
  bit   post_rst[2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic op_e decode_ref(
    input logic [6:0] o,
    input logic [2:0] f3,
    input logic [6:0] f7
  );
    op_e base[8] = '{O_ADD, O_SLL, O_SLT, O_SLTU,
                     O_XOR, O_SRL, O_OR, O_AND};
    op_e r = O_ILL;
    case (o)
      7'b0000011, 7'b0100011,
      7'b1101111, 7'b0010111: r = O_ADD;
      7'b1100111: if (f3 == 3'd0) r = O_ADD;
      7'b0110111: r = O_PASSB;
      7'b1100011: begin
        if (f3 == 3'd0 || f3 == 3'd1) r = O_SUB;
        else if (f3 == 3'd4 || f3 == 3'd5) r = O_SLT;
        else if (f3 == 3'd6 || f3 == 3'd7) r = O_SLTU;
      end
      7'b0110011: begin
        if (f7 == 7'h00) r = base[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) r = O_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) r = O_SRA;
      end
      7'b0010011: begin
        if (f3 == 3'd1) r = (f7 == 7'h00) ? O_SLL : O_ILL;
        else if (f3 == 3'd5 && f7 == 7'h00) r = O_SRL;
        else if (f3 == 3'd5 && f7 == 7'h20) r = O_SRA;
        else if (f3 != 3'd5) r = base[f3];
      end
      default: r = O_ILL;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] code_of(input op_e op);
    case (op)
      O_AND:   return 4'b0000;
      O_OR:    return 4'b0001;
      O_ADD:   return 4'b0010;
      O_XOR:   return 4'b0011;
      O_SLL:   return 4'b0100;
      O_SRL:   return 4'b0101;
      O_SUB:   return 4'b0110;
      O_SRA:   return 4'b0111;
      O_SLT:   return 4'b1000;
      O_SLTU:  return 4'b1001;
      O_PASSB: return 4'b1010;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic exp_t model(
    input int k,
    input logic [6:0] o,
    input logic [2:0] f3,
    input logic [6:0] f7,
    input logic [31:0] a,
    input logic [31:0] b
  );
    exp_t e;
    op_e  op;
    int   sh;
    bit   shifty;
    logic [31:0] fill;
    op = decode_ref(o, f3, f7);
    sh = int'(b % 32);
    fill = ~(32'hFFFF_FFFF >> sh);
    case (op)
      O_ADD:   e.res = a + b;
      O_SUB:   e.res = a - b;
      O_SLL:   e.res = a << sh;
      O_SRL:   e.res = a >> sh;
      O_SRA:   e.res = (a >> sh) | (a[31] ? fill : 32'h0);
      O_SLT:   e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      O_SLTU:  e.res = (a < b) ? 32'd1 : 32'd0;
      O_XOR:   e.res = a ^ b;
      O_OR:    e.res = a | b;
      O_AND:   e.res = a & b;
      O_PASSB: e.res = b;
      default: e.res = 32'h0;
    endcase
    e.ctl = code_of(op);
    e.ill = (op == O_ILL);
    shifty = (op == O_SLL) || (op == O_SRL) || (op == O_SRA);
    e.lat = (k == 0 && shifty && sh != 0) ? sh + 1 : 1;
    e.acc = 0;
    return e;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] req
  );
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Scoreboard monitor: sole place where comparisons happen.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          pres[k]     = 1'b0;
          post_rst[k] = 1'b1;
        end else if (post_rst[k]) begin
          post_rst[k] = 1'b0;
          chk($sformatf("d%0d_rst_valid", k), ov[k], 0);
          chk($sformatf("d%0d_rst_ready", k), ir[k], 1);
          chk($sformatf("d%0d_rst_result", k), res[k], 0);
          chk($sformatf("d%0d_rst_zero", k), zr[k], 0);
          chk($sformatf("d%0d_rst_ctl", k), ctl[k], 0);
          chk($sformatf("d%0d_rst_illegal", k), ill[k], 0);
        end else if (ov[k]) begin
          if (sbq[k].size() == 0) begin
            chk($sformatf("d%0d_spurious_valid", k), ov[k], 0);
          end else begin
            e = sbq[k][0];
            if (!pres[k]) begin
              pres[k] = 1'b1;
              chk($sformatf("d%0d_latency", k), cyc - e.acc, e.lat);
            end
            chk($sformatf("d%0d_result", k), res[k], e.res);
            chk($sformatf("d%0d_zero", k), zr[k], e.res == 0);
            chk($sformatf("d%0d_alu_control", k), ctl[k], e.ctl);
            chk($sformatf("d%0d_illegal", k), ill[k], e.ill);
            chk($sformatf("d%0d_ready_done", k), ir[k], ordy[k]);
            if (ordy[k]) begin
              void'(sbq[k].pop_front());
              pres[k] = 1'b0;
            end
          end
        end else begin
          chk($sformatf("d%0d_ready_nodone", k), ir[k],
              sbq[k].size() == 0);
        end
      end
    end
  end

  // out_ready: 0 = always ready, 1 = stalled, 2 = random.
  initial begin
    ordy[0] = 1'b1;
    ordy[1] = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
        if (mode == 0) ordy[k] = 1'b1;
        else if (mode == 1) ordy[k] = 1'b0;
        else ordy[k] = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic issue(
    input int k,
    input logic [6:0] o,
    input logic [2:0] f3,
    input logic [6:0] f7,
    input logic [31:0] a,
    input logic [31:0] b
  );
    exp_t e;
    int   t;
    e = model(k, o, f3, f7, a, b);
    in_valid[k] = 1'b1;
    opc[k] = o;
    fn3[k] = f3;
    fn7[k] = f7;
    opa[k] = a;
    opb[k] = b;
    t = 0;
    @(negedge clk);
    while (!ir[k]) begin
      t++;
      if (t > 400) begin
        $display("FAIL d%0d_accept_timeout: in_ready 0, expected 1", k);
        $fatal(1, "handshake timeout");
      end
      @(negedge clk);
    end
    e.acc = cyc;
    @(posedge clk);
    #1;
    sbq[k].push_back(e);
    in_valid[k] = 1'b0;
    opc[k] = 7'($urandom);
    fn3[k] = 3'($urandom);
    fn7[k] = 7'($urandom);
    opa[k] = $urandom;
    opb[k] = $urandom;
  endtask

  task automatic drain(input int k);
    int t;
    t = 0;
    while (sbq[k].size() != 0) begin
      @(negedge clk);
      t++;
      if (t > 3000) begin
        $display("FAIL d%0d_drain_timeout: %0d pending, expected 0",
                 k, sbq[k].size());
        $fatal(1, "drain timeout");
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_val(input logic [31:0] other);
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return other;
      4:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_op(input int k);
    logic [6:0]  o;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    case ($urandom_range(0, 9))
      0: o = 7'b0000011;
      1: o = 7'b0100011;
      2: o = 7'b1101111;
      3: o = 7'b0010111;
      4: o = 7'b1100111;
      5: o = 7'b0110111;
      6: o = 7'b1100011;
      7: o = 7'b0110011;
      8: o = 7'b0010011;
      default: o = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0, 1: f7 = 7'h00;
      2:    f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    a = pick_val($urandom);
    b = pick_val(a);
    issue(k, o, 3'($urandom), f7, a, b);
    if ($urandom_range(0, 4) == 0) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
  endtask

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;

  initial begin
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0;
      opc[k] = '0;
      fn3[k] = '0;
      fn7[k] = '0;
      opa[k] = '0;
      opb[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(0, OP, 3'd0, 7'h00, 32'd5, 32'd7);
    issue(0, OP, 3'd0, 7'h20, 32'd9, 32'd9);
    issue(0, BRANCH, 3'd4, 7'h00, 32'hFFFF_FFFF, 32'd1);
    issue(0, BRANCH, 3'd6, 7'h00, 32'hFFFF_FFFF, 32'd1);
    issue(0, OPIMM, 3'd5, 7'h20, 32'h8000_0000, 32'd4);
    issue(0, OP, 3'd0, 7'h01, 32'd3, 32'd4);
    issue(0, JALR, 3'd2, 7'h00, 32'd3, 32'd4);
    issue(0, OP, 3'd1, 7'h00, 32'h1234_5678, 32'hFFFF_FFE0);
    issue(0, OPIMM, 3'd5, 7'h00, 32'hF000_0001, 32'd31);
    drain(0);

    issue(1, OPIMM, 3'd5, 7'h20, 32'h8000_0000, 32'd4);
    issue(1, OP, 3'd0, 7'h00, 32'd5, 32'd7);
    issue(1, OP, 3'd1, 7'h00, 32'h0000_0001, 32'd31);
    drain(1);

    mode = 1;
    issue(0, LUI, 3'd0, 7'h00, 32'hDEAD_BEEF, 32'h1234_5000);
    repeat (10) @(posedge clk);
    #1;
    mode = 0;
    drain(0);

    issue(0, OP, 3'd1, 7'h00, 32'h0000_00FF, 32'd20);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    sbq[0].delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(0, OP, 3'd0, 7'h00, 32'd100, 32'd23);
    drain(0);

    mode = 2;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 150; i++) rand_op(k);
      drain(k);
    end
    mode = 0;
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor of the combinational ALU decoder.
- Decodes opcode/func3/func7 for the full RV32I integer ALU op set, then executes the op on captured operands.
- Shifts run either iteratively (one bit per cycle) or as a single-cycle barrel shift, selected by parameter.
- Sits between the register-read stage and writeback, with valid/ready handshakes on both sides.
- Illegal encodings raise an `illegal` flag instead of printing a simulation message.

Parameters:
- XLEN, 32, operand/result width; power of two, >= 8.
- ITER_SHIFT, 1, 1 = shift one bit per cycle; 0 = single-cycle barrel shift.
- SHW, $clog2(XLEN), shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- opcode  in  7  instruction opcode.
- func3  in  3  instruction func3.
- func7  in  7  instruction func7.
- op_a  in  XLEN  operand A.
- op_b  in  XLEN  operand B (register or immediate).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  ALU result.
- zero  out  1  result == 0.
- alu_control  out  4  decoded op for the held result.
- illegal  out  1  held op was an unsupported encoding.

Behaviour:
- Reset values: state IDLE, out_valid 0, result 0, zero 0, alu_control 4'b0000, illegal 0, shift counter 0.
- Reset mid-operation (SHIFT or DONE) abandons the op; the result is never presented.
- alu_control encodings:
  - AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111.
  - SLT 1000, SLTU 1001, PASSB 1010, ILLEGAL 1111.
- Decode, LOAD / STORE / JAL / AUIPC:
  - LOAD 0000011, STORE 0100011 -> ADD (any func3/func7).
  - JAL 1101111 -> ADD (any func3/func7).
  - AUIPC 0010111 -> ADD (any func3/func7).
- Decode, JALR 1100111: ADD if func3 = 000; otherwise ILLEGAL.
- Decode, LUI 0110111: PASSB.
- Decode, BRANCH 1100011:
  - func3 000/001 -> SUB; 100/101 -> SLT; 110/111 -> SLTU; 010/011 -> ILLEGAL.
- Decode, OP 0110011:
  - func7 0000000: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - func7 0100000: 000 SUB, 101 SRA; other func3 -> ILLEGAL.
  - Any other func7 -> ILLEGAL.
- Decode, OP-IMM 0010011:
  - func7 ignored for 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - 001 -> SLL only if func7 = 0000000.
  - 101 -> SRL if func7 = 0000000; SRA if func7 = 0100000.
  - All other combinations -> ILLEGAL.
- Any other opcode -> ILLEGAL.
- ILLEGAL ops: result 0, illegal 1, alu_control 1111.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT is a signed compare, SLTU unsigned; result is zero-extended 0/1.
  - Shift amount = op_b[SHW-1:0]; upper op_b bits ignored. SRA replicates op_a[XLEN-1].
  - PASSB result = op_b.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state == IDLE) || (state == DONE && out_ready).
- On accept: operands, op and flags are captured; later input changes are ignored.
- Non-shift op, any ILLEGAL op, ITER_SHIFT = 0, or shift amount 0 -> go to DONE.
  - out_valid rises the cycle after accept (latency 1).
- Shift op with ITER_SHIFT = 1 and shamt > 0 -> go to SHIFT with counter = shamt.
  - Each SHIFT cycle: shift the held value one bit, decrement the counter.
  - When the counter reaches 0, go to DONE. Latency = shamt + 1 cycles.
  - in_ready is 0 throughout SHIFT.
- DONE:
  - out_valid = 1; result, zero, alu_control and illegal are held stable until out_ready.
  - out_ready with in_valid: accept the new op that cycle (back-to-back, one op per cycle for latency-1 ops).
  - out_ready without in_valid: go to IDLE; out_valid drops next cycle.
- zero is registered alongside result and is only meaningful while out_valid = 1.

Test Plan:
- Add, back-to-back: OP/000/0000000, a=5, b=7 -> result 12, zero 0, alu_control 0010 one cycle later. Second op (SUB 9-9) in the same cycle as out_ready -> result 0, zero 1 on the next cycle.
- Signed vs unsigned compare: BRANCH func3 100, a=32'hFFFFFFFF, b=1 -> result 1 (SLT). func3 110 with the same operands -> result 0 (SLTU).
- Iterative SRA, ITER_SHIFT=1: OP-IMM/101/0100000, a=32'h80000000, b=4 -> result 32'hF8000000. out_valid exactly 5 cycles after accept; in_ready 0 during SHIFT. Repeat with ITER_SHIFT=0 -> same result, latency 1.
- Illegal: OP/000/0000001 -> illegal 1, alu_control 1111, result 0. JALR with func3 010 -> illegal 1.
- Backpressure: hold out_ready=0 for 10 cycles after LUI b=32'h12345000 -> result stays 32'h12345000, in_ready 0, then releases on out_ready.
- Reset mid-shift: SLL with b=20, assert rst at shift cycle 3 -> out_valid 0 and in_ready 1 the cycle after reset deasserts; the next ADD completes normally.
